rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Merges the two writers of the integer register file into its single write port: the in-order pipeline writeback (fixed timing, cannot stall) and a long-latency unit (multiply/divide, valid/ready handshake). Buffers long-latency results in a small FIFO and drains them into idle write slots. Keeps a pending-write scoreboard so decode can stall on operands still owed by the long-latency unit. Sits between the writeback stage / MDU and the register file write port (`wen`, `regWAddr`, `regWData`).

## Interface
- `XLEN`, 32, data width
- `DEPTH`, 2, long-latency result FIFO entries (power of two, ≥2)
- `clk`  in  1  clock, posedge
- `reset`  in  1  reset, synchronous, active-high
- `pipe_wen`  in  1  pipeline writeback valid this cycle
- `pipe_rd`  in  5  pipeline destination register
- `pipe_wdata`  in  XLEN  pipeline result
- `ll_issue`  in  1  decode issues a long-latency op this cycle
- `ll_issue_rd`  in  5  destination of the issued op
- `ll_valid`  in  1  long-latency result valid
- `ll_rd`  in  5  long-latency result destination
- `ll_wdata`  in  XLEN  long-latency result
- `ll_ready`  out  1  FIFO can accept (`!full`), registered-state only
- `rs1_q`, `rs2_q`, `rd_q`  in  5 each  decode query addresses
- `rs1_busy`, `rs2_busy`, `rd_busy`  out  1 each  combinational scoreboard lookup; x0 always 0
- `rf_wen`  out  1  register file write enable
- `rf_waddr`  out  5  register file write address
- `rf_wdata`  out  XLEN  register file write data

## Operation
- Long-latency push: `ll_valid && ll_ready` writes {`ll_rd`, `ll_wdata`} at tail.
- Slot arbitration per cycle: pipeline slot is "used" iff `pipe_wen && pipe_rd != 0`.
  - Used: register pipeline write to outputs; FIFO holds.
  - Not used, FIFO non-empty: pop head, register it to outputs, clear scoreboard bit of head rd.
  - Otherwise: `rf_wen` = 0 next cycle; `rf_waddr`/`rf_wdata` hold last values.
- Pipeline writes to x0 are dropped (`rf_wen` stays 0) and free the slot for the FIFO.
- Scoreboard: 32-bit vector, bit 0 hard-wired 0. `ll_issue` with rd≠0 sets bit. Pop clears bit of popped rd. Same-cycle set and clear of same bit: set wins.
- Results with `ll_rd` = 0 are accepted, popped in normal order, written with `rf_wen` = 0 (slot consumed, no write).
- Decode contract: no issue (pipeline or long-latency) to a register whose `rd_busy` = 1; arbiter does not check WAW.
- Push and pop in the same cycle allowed when not full; occupancy unchanged.

## Timing
- Reset (synchronous): FIFO empty, pointers 0, scoreboard all 0, `rf_wen` 0, `rf_waddr` 0, `rf_wdata` 0, `ll_ready` 1 the cycle after reset asserts low... i.e. `ll_ready` = 1 whenever not in reset-cleared-full state; during `reset` = 1 `ll_ready` forced 0.
- Reset mid-operation discards all buffered results and scoreboard state; no write issued on the cycle after reset.
- Pipeline write latency: 1 cycle (input cycle N → `rf_wen` valid cycle N+1). Register file writes on following negedge and bypasses to readers.
- Long-latency latency: minimum 2 cycles from accept to `rf_wen` (push at N, pop at N+1 if slot idle, output at N+2). Unbounded under continuous pipeline writes.
- `ll_ready` depends on occupancy only; when full, deasserted even if a pop occurs that cycle (re-asserts next cycle).
- Busy outputs combinational from registered scoreboard; a bit set by `ll_issue` at edge N reads busy from cycle N+1; bit cleared at pop edge reads 0 from the same cycle `rf_wen` is asserted.
- FIFO pointers wrap modulo DEPTH; full/empty via extra pointer bit.

## Structure
- Shared package: `XLEN`, register address width (5), and a `wb_entry_t` {rd, wdata} struct also used by the MDU result port.
- One natural sub-module: `wb_fifo` (parameterised DEPTH, push/pop, full/empty); scoreboard and arbitration in the top.

## Test plan
- Reset: assert `reset` 2 cycles with `ll_valid`=1 → `rf_wen`=0, `ll_ready`=0 during, all busy=0, FIFO empty after.
- Pipeline only: `pipe_wen`=1, rd=5, data 0xDEADBEEF at N → `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF at N+1; rd=0 → `rf_wen`=0.
- Issue/drain: `ll_issue` rd=7 → `rs1_q`=7 busy=1; push rd=7 data 0x12345678 with pipeline idle → write appears 2 cycles after push, busy=0 same cycle.
- Contention: pipeline writes every cycle for 6 cycles while 2 LL results pushed → `ll_ready`=0 after second push, no LL write until pipeline idles, then both in push order on consecutive cycles.
- Full with simultaneous pop: FIFO full, pipeline idle, `ll_valid`=1 → no accept that cycle, head written, `ll_ready`=1 next cycle, third result accepted.
- Set/clear collision and x0: pop of rd=9 same cycle as `ll_issue` rd=9 → bit 9 remains set; `ll_issue` rd=0 → `rs1_busy` for x0 stays 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Types shared by the register-file write arbiter and the long-latency result port.
package rf_write_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_REG = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } wb_entry_t;

endpackage

// File: rtl/rf_write_arbiter_wb_fifo.sv
// Small result buffer for long-latency writebacks; extra pointer bit separates full from empty.
module rf_write_arbiter_wb_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    wb_entry_t   r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single register
// file write port, and tracks registers still owed by the long-latency unit.
module rf_write_arbiter #(
    parameter int XLEN  = rf_write_arbiter_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            ll_issue,
    input  logic [4:0]      ll_issue_rd,
    input  logic            ll_valid,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_wdata,
    output logic            ll_ready,
    input  logic [4:0]      rs1_q,
    input  logic [4:0]      rs2_q,
    input  logic [4:0]      rd_q,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    import rf_write_arbiter_pkg::*;

    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic [NUM_REG-1:0] r_sb;

    logic            w_pipe_used;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    wb_entry_t       w_push_data;
    wb_entry_t       w_head;
    logic [NUM_REG-1:0] w_sb_set;
    logic [NUM_REG-1:0] w_sb_clr;
    logic [NUM_REG-1:0] w_sb_next;

    // A pipeline write to x0 is dropped and leaves the slot free for the FIFO.
    assign w_pipe_used = pipe_wen && (pipe_rd != 5'd0);
    assign ll_ready    = !reset && !w_full;
    assign w_push      = ll_valid && ll_ready;
    assign w_pop       = !reset && !w_pipe_used && !w_empty;

    assign w_push_data.rd    = ll_rd;
    assign w_push_data.wdata = ll_wdata;

    rf_write_arbiter_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_pipe_used) begin
            r_wen   <= 1'b1;
            r_waddr <= pipe_rd;
            r_wdata <= pipe_wdata;
        end else if (w_pop) begin
            r_wen   <= (w_head.rd != 5'd0);
            r_waddr <= w_head.rd;
            r_wdata <= w_head.wdata;
        end else begin
            r_wen   <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle issue to the popped register stays busy.
    always_comb begin
        w_sb_set = '0;
        w_sb_clr = '0;
        if (ll_issue) w_sb_set[ll_issue_rd] = 1'b1;
        if (w_pop)    w_sb_clr[w_head.rd]   = 1'b1;
        w_sb_next    = (r_sb & ~w_sb_clr) | w_sb_set;
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_sb <= '0;
        else       r_sb <= w_sb_next;
    end

    assign rs1_busy = r_sb[rs1_q];
    assign rs2_busy = r_sb[rs2_q];
    assign rd_busy  = r_sb[rd_q];

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: pipeline vector table plus hand-written LL sequences.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter #(.XLEN(32), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_wen    (pipe_wen),
        .pipe_rd     (pipe_rd),
        .pipe_wdata  (pipe_wdata),
        .ll_issue    (ll_issue),
        .ll_issue_rd (ll_issue_rd),
        .ll_valid    (ll_valid),
        .ll_rd       (ll_rd),
        .ll_wdata    (ll_wdata),
        .ll_ready    (ll_ready),
        .rs1_q       (rs1_q),
        .rs2_q       (rs2_q),
        .rd_q        (rd_q),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string name, input logic wen, input logic [4:0] addr, input logic [31:0] data);
        chk({name, ".wen"}, {31'd0, rf_wen}, {31'd0, wen});
        chk({name, ".waddr"}, {27'd0, rf_waddr}, {27'd0, addr});
        chk({name, ".wdata"}, rf_wdata, data);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd5,  32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd3,  32'h22222222, 1'b0, 5'd5,  32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
        vecs[5] = '{1'b0, 5'd1,  32'hFFFFFFFF, 1'b0, 5'd1,  32'h00000000};

        reset = 1'b1; pipe_wen = 0; pipe_rd = 0; pipe_wdata = 0;
        ll_issue = 0; ll_issue_rd = 0; ll_valid = 1'b1; ll_rd = 5'd3; ll_wdata = 32'h0BAD0BAD;
        rs1_q = 5'd7; rs2_q = 5'd9; rd_q = 5'd3;

        // Reset held two cycles with a result offered: nothing accepted or written.
        tick();
        chk("rst1.ll_ready", {31'd0, ll_ready}, 32'd0);
        chk_wr("rst1", 1'b0, 5'd0, 32'd0);
        tick();
        chk("rst2.ll_ready", {31'd0, ll_ready}, 32'd0);
        chk("rst2.busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        reset = 1'b0; ll_valid = 1'b0;
        #1;
        chk("rst.ll_ready_after", {31'd0, ll_ready}, 32'd1);
        tick();
        tick();
        chk_wr("rst.fifo_empty", 1'b0, 5'd0, 32'd0);

        for (int i = 0; i < 6; i++) begin
            pipe_wen = vecs[i].wen; pipe_rd = vecs[i].rd; pipe_wdata = vecs[i].wdata;
            tick();
            chk_wr($sformatf("vec%0d", i), vecs[i].exp_wen, vecs[i].exp_waddr, vecs[i].exp_wdata);
            chk($sformatf("vec%0d.ll_ready", i), {31'd0, ll_ready}, 32'd1);
        end
        pipe_wen = 0;

        // Issue rd=7, then its result drains two cycles after the push.
        ll_issue = 1; ll_issue_rd = 5'd7; rs1_q = 5'd7; rd_q = 5'd7;
        #1;
        chk("issue.busy_before", {31'd0, rs1_busy}, 32'd0);
        tick();
        ll_issue = 0;
        #1;
        chk("issue.rs1_busy", {31'd0, rs1_busy}, 32'd1);
        chk("issue.rd_busy", {31'd0, rd_busy}, 32'd1);
        ll_valid = 1; ll_rd = 5'd7; ll_wdata = 32'h12345678;
        tick();
        ll_valid = 0;
        chk("drain.push_cycle_wen", {31'd0, rf_wen}, 32'd0);
        chk("drain.still_busy", {31'd0, rs1_busy}, 32'd1);
        tick();
        chk_wr("drain", 1'b1, 5'd7, 32'h12345678);
        chk("drain.busy_cleared", {31'd0, rs1_busy}, 32'd0);
        tick();
        chk("drain.idle", {31'd0, rf_wen}, 32'd0);

        // Six back-to-back pipeline writes starve the FIFO of slots.
        for (int i = 0; i < 6; i++) begin
            pipe_wen = 1; pipe_rd = 5'(10 + i); pipe_wdata = 32'h100 + i;
            ll_valid = (i < 2); ll_rd = 5'(20 + i); ll_wdata = 32'hAAAA0001 + i;
            tick();
            chk_wr($sformatf("cont%0d", i), 1'b1, 5'(10 + i), 32'h100 + i);
            chk($sformatf("cont%0d.ll_ready", i), {31'd0, ll_ready}, (i == 0) ? 32'd1 : 32'd0);
        end
        pipe_wen = 0; ll_valid = 0;
        tick();
        chk_wr("cont.ll0", 1'b1, 5'd20, 32'hAAAA0001);
        chk("cont.ready_back", {31'd0, ll_ready}, 32'd1);
        tick();
        chk_wr("cont.ll1", 1'b1, 5'd21, 32'hAAAA0002);
        tick();
        chk("cont.idle", {31'd0, rf_wen}, 32'd0);

        // Full FIFO with a pop in the same cycle: offer is refused until next cycle.
        pipe_wen = 1; pipe_rd = 5'd2; pipe_wdata = 32'h2;
        ll_valid = 1; ll_rd = 5'd22; ll_wdata = 32'hB1;
        tick();
        ll_rd = 5'd23; ll_wdata = 32'hB2;
        tick();
        pipe_wen = 0; ll_rd = 5'd24; ll_wdata = 32'hB3;
        #1;
        chk("full.ll_ready", {31'd0, ll_ready}, 32'd0);
        tick();
        chk_wr("full.head", 1'b1, 5'd22, 32'hB1);
        chk("full.ready_next", {31'd0, ll_ready}, 32'd1);
        tick();
        ll_valid = 0;
        chk_wr("full.second", 1'b1, 5'd23, 32'hB2);
        tick();
        chk_wr("full.third", 1'b1, 5'd24, 32'hB3);
        tick();
        chk("full.idle", {31'd0, rf_wen}, 32'd0);

        // Pop of rd=9 collides with a new issue to rd=9: busy stays set.
        ll_issue = 1; ll_issue_rd = 5'd9; rs1_q = 5'd9;
        tick();
        ll_issue = 0; ll_valid = 1; ll_rd = 5'd9; ll_wdata = 32'hC9C9C9C9;
        tick();
        ll_valid = 0; ll_issue = 1; ll_issue_rd = 5'd9;
        tick();
        ll_issue = 0;
        chk_wr("coll.pop9", 1'b1, 5'd9, 32'hC9C9C9C9);
        chk("coll.busy9", {31'd0, rs1_busy}, 32'd1);
        ll_issue = 1; ll_issue_rd = 5'd0; rs2_q = 5'd0;
        tick();
        ll_issue = 0;
        chk("x0.rs2_busy", {31'd0, rs2_busy}, 32'd0);

        // A result for x0 consumes a slot without writing.
        ll_valid = 1; ll_rd = 5'd0; ll_wdata = 32'hE0E0E0E0;
        tick();
        ll_valid = 0;
        tick();
        chk("x0.ll_wen", {31'd0, rf_wen}, 32'd0);

        // Reset mid-operation discards a buffered result and the scoreboard.
        pipe_wen = 1; pipe_rd = 5'd4; pipe_wdata = 32'h44;
        ll_valid = 1; ll_rd = 5'd25; ll_wdata = 32'hD5;
        tick();
        pipe_wen = 0; ll_valid = 0; reset = 1;
        tick();
        chk("midrst.wen", {31'd0, rf_wen}, 32'd0);
        reset = 0;
        tick();
        chk("midrst.after1", {31'd0, rf_wen}, 32'd0);
        tick();
        chk("midrst.after2", {31'd0, rf_wen}, 32'd0);
        chk("midrst.busy9", {31'd0, rs1_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
